// File: rtl/blockmem_responder.sv
// Block-refill responder: one request at a time, fixed LATENCY, returns blocks idx and idx+1.
// Latency: resp_valid rises LATENCY edges after accept; req_ready held low until the response handshake.
module blockmem_responder #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_W    = 256,
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_write,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [BLOCK_W-1:0] resp_data0,
  output logic [BLOCK_W-1:0] resp_data1
);

  localparam int OFF_W = $clog2(BLOCK_W / 8);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] idx_nxt;
  logic                  accept;
  logic [BLOCK_W-1:0]    mem [DEPTH];
  logic                  unused_addr_bits;

  assign req_idx = req_addr[OFF_W +: DEPTH_LOG2];
  assign idx_nxt = idx_q + 1'b1;  // wraps from the last block to block 0
  assign accept  = req_valid && req_ready;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:OFF_W+DEPTH_LOG2], req_addr[OFF_W-1:0]};

  // Storage survives reset; rst_n gates writes so nothing commits while reset is held.
  always_ff @(posedge clk) begin
    if (accept && rst_n && req_write)
      mem[req_idx] <= req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data0 <= '0;
      resp_data1 <= '0;
      cnt        <= '0;
      idx_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q     <= req_idx;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Written data is already in mem, so the response sees it without a bypass.
          if (cnt == 4'd0) begin
            resp_data0 <= mem[idx_q];
            resp_data1 <= mem[idx_nxt];
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blockmem_responder.sv
// Directed bench for blockmem_responder: LATENCY=4 instance for function, LATENCY=1 instance for throughput.
module tb_blockmem_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic [31:0]  req_addr;
  logic [255:0] req_wdata, resp_data0, resp_data1;

  logic         req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1;
  logic [31:0]  req_addr1;
  logic [255:0] req_wdata1, resp_data0_1, resp_data1_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blockmem_responder #(.ADDR_W(32), .BLOCK_W(256), .DEPTH_LOG2(6), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data0(resp_data0), .resp_data1(resp_data1)
  );

  blockmem_responder #(.ADDR_W(32), .BLOCK_W(256), .DEPTH_LOG2(6), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
    .req_write(req_write1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_data0(resp_data0_1), .resp_data1(resp_data1_1)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    logic [255:0] e0;
    logic [255:0] e1;
    logic         chk1;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [255:0] rep(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the LATENCY=4 instance with resp_ready held high; starts and ends at a negedge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [255:0] wd,
                       output int lat, output logic [255:0] d0, output logic [255:0] d1);
    chk("req_ready_before_req", {255'd0, req_ready}, 256'd1);
    req_addr = a; req_write = w; req_wdata = wd; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d0 = resp_data0;
    d1 = resp_data1;
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid_after_hs", {255'd0, resp_valid}, 256'd0);
    chk("req_ready_after_hs", {255'd0, req_ready}, 256'd1);
  endtask

  initial begin
    int lat;
    logic [255:0] d0, d1, h0, h1;
    logic saw_resp;

    vecs[0]  = '{32'h80,   1'b1, rep(32'h4),        rep(32'h4),        '0,                1'b0};
    vecs[1]  = '{32'h60,   1'b1, rep(32'hA5A5_0003), rep(32'hA5A5_0003), rep(32'h4),      1'b1};
    vecs[2]  = '{32'h60,   1'b0, '0,                rep(32'hA5A5_0003), rep(32'h4),       1'b1};
    vecs[3]  = '{32'hA0,   1'b1, rep(32'h5),        rep(32'h5),        '0,                1'b0};
    vecs[4]  = '{32'hC0,   1'b1, rep(32'h6),        rep(32'h6),        '0,                1'b0};
    vecs[5]  = '{32'hB7,   1'b0, '0,                rep(32'h5),        rep(32'h6),        1'b1};
    vecs[6]  = '{32'h7E0,  1'b1, rep(32'h3F),       rep(32'h3F),       '0,                1'b0};
    vecs[7]  = '{32'h0,    1'b1, rep(32'h0),        rep(32'h0),        '0,                1'b0};
    vecs[8]  = '{32'h7E0,  1'b0, '0,                rep(32'h3F),       rep(32'h0),        1'b1};
    vecs[9]  = '{32'h8060, 1'b0, '0,                rep(32'hA5A5_0003), rep(32'h4),       1'b1};
    vecs[10] = '{32'hA0,   1'b1, rep(32'hDEAD_0055), rep(32'hDEAD_0055), rep(32'h6),      1'b1};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {255'd0, req_ready}, 256'd1);
    chk("rst_resp_valid", {255'd0, resp_valid}, 256'd0);
    chk("rst_data0", resp_data0, 256'd0);
    chk("rst_data1", resp_data1, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].addr, vecs[i].wr, vecs[i].wdata, lat, d0, d1);
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd4);
      chk($sformatf("vec%0d_data0", i), d0, vecs[i].e0);
      if (vecs[i].chk1) chk($sformatf("vec%0d_data1", i), d1, vecs[i].e1);
    end

    // Backpressure: response held 10 cycles while competing write pulses arrive.
    req_addr = 32'hA0; req_write = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 256'(lat), 256'd4);
    h0 = resp_data0;
    h1 = resp_data1;
    chk("bp_data0", h0, rep(32'hDEAD_0055));
    chk("bp_data1", h1, rep(32'h6));
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0]; req_write = 1'b1; req_addr = 32'hC0; req_wdata = rep(32'hBAD0_BAD0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d_resp_valid", i), {255'd0, resp_valid}, 256'd1);
      chk($sformatf("bp%0d_req_ready", i), {255'd0, req_ready}, 256'd0);
      chk($sformatf("bp%0d_data0", i), resp_data0, h0);
      chk($sformatf("bp%0d_data1", i), resp_data1, h1);
    end
    req_valid = 1'b0; req_write = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_resp_valid", {255'd0, resp_valid}, 256'd0);
    chk("bp_release_req_ready", {255'd0, req_ready}, 256'd1);

    // Reset two cycles into the wait of a write to block 7.
    req_addr = 32'hE0; req_write = 1'b1; req_wdata = rep(32'h77); req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {255'd0, req_ready}, 256'd1);
    chk("midrst_resp_valid", {255'd0, resp_valid}, 256'd0);
    chk("midrst_data0", resp_data0, 256'd0);
    chk("midrst_data1", resp_data1, 256'd0);
    @(negedge clk);
    req_addr = 32'hC0; req_write = 1'b1; req_wdata = rep(32'hBAD1_BAD1); req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("postrst_no_resp", {255'd0, saw_resp}, 256'd0);
    issue(32'hE0, 1'b0, '0, lat, d0, d1);
    chk("postrst_blk7_latency", 256'(lat), 256'd4);
    chk("postrst_blk7_data0", d0, rep(32'h77));
    issue(32'hC0, 1'b0, '0, lat, d0, d1);
    chk("blk6_untouched", d0, rep(32'h6));

    // LATENCY=1: write then continuous reads with resp_ready high; one accept every 3 cycles.
    req_addr1 = 32'h40; req_write1 = 1'b1; req_wdata1 = rep(32'h1122_0002); req_valid1 = 1'b1;
    resp_ready1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("l1_cyc%0d_req_ready", i), {255'd0, req_ready1}, 256'((i % 3) == 0));
      chk($sformatf("l1_cyc%0d_resp_valid", i), {255'd0, resp_valid1}, 256'((i % 3) == 2));
      if (i == 2 || i == 5) chk($sformatf("l1_cyc%0d_data0", i), resp_data0_1, rep(32'h1122_0002));
      @(posedge clk);
      @(negedge clk);
      req_write1 = 1'b0;
    end
    req_valid1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
